// File: rtl/multicycle_control_unit.sv
// Control FSM for the multi-cycle CPU: steps each instruction through IF/ID/EXE/MEM/WB.
// Outputs are combinational from state, opcode and zero; no handshake, one state per clock.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ALUM2Reg,
  output logic [1:0] RegOut,
  output logic       DataMemRw,
  output logic [1:0] PCSrc,
  output logic       ExtSel,
  output logic       WrRegData,
  output logic [2:0] state
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] next_state;
  logic       op_known;
  logic       pc_we, ir_we, reg_we, mem_we;

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT,
      OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: begin
        if (opcode == OP_HALT)
          next_state = S_HALT;
        else if (!op_known || opcode == OP_J || opcode == OP_JR || opcode == OP_JAL)
          next_state = S_IF;
        else
          next_state = S_EXE;
      end
      S_EXE: begin
        if (opcode == OP_BEQ)                         next_state = S_IF;
        else if (opcode == OP_LW || opcode == OP_SW)  next_state = S_MEM;
        else                                          next_state = S_WB;
      end
      S_MEM:   next_state = (opcode == OP_LW) ? S_WB : S_IF;
      S_WB:    next_state = S_IF;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    InsMemRW  = 1'b1;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ALUM2Reg  = 1'b0;
    RegOut    = 2'b00;
    PCSrc     = 2'b00;
    ExtSel    = 1'b0;
    WrRegData = 1'b0;
    case (state)
      S_IF: ir_we = 1'b1;
      S_ID: begin
        case (opcode)
          OP_J: begin
            PCSrc = 2'b11;
            pc_we = 1'b1;
          end
          OP_JR: begin
            PCSrc = 2'b10;
            pc_we = 1'b1;
          end
          OP_JAL: begin
            // PC has not advanced yet, so PC+4 on the write port is the return address
            reg_we    = 1'b1;
            RegOut    = 2'b00;
            WrRegData = 1'b0;
            PCSrc     = 2'b11;
            pc_we     = 1'b1;
          end
          default: begin
            if (!op_known) pc_we = 1'b1;
          end
        endcase
      end
      S_EXE: begin
        ALUSrcB = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                  (opcode == OP_LW)   || (opcode == OP_SW);
        ExtSel  = (opcode == OP_ADDI) || (opcode == OP_LW) ||
                  (opcode == OP_SW)   || (opcode == OP_BEQ);
        case (opcode)
          OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
          OP_OR, OP_ORI:  ALUOp = ALU_OR;
          OP_AND:         ALUOp = ALU_AND;
          OP_SLT:         ALUOp = ALU_SLT;
          default:        ALUOp = ALU_ADD;
        endcase
        if (opcode == OP_BEQ) begin
          PCSrc = zero ? 2'b01 : 2'b00;
          pc_we = 1'b1;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          mem_we = 1'b1;
          pc_we  = 1'b1;
        end else begin
          ALUM2Reg = 1'b1;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        WrRegData = 1'b1;
        pc_we     = 1'b1;
        RegOut    = (opcode == OP_ADDI || opcode == OP_ORI || opcode == OP_LW) ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  // Reset abandons the instruction in flight: no state-changing write may leak out.
  assign PCWre     = pc_we  & ~reset;
  assign IRWre     = ir_we  & ~reset;
  assign RegWre    = reg_we & ~reset;
  assign DataMemRw = mem_we & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class state by state.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUM2Reg, DataMemRw, ExtSel, WrRegData;
  logic [2:0] ALUOp, state;
  logic [1:0] RegOut, PCSrc;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ALUM2Reg(ALUM2Reg), .RegOut(RegOut),
    .DataMemRw(DataMemRw), .PCSrc(PCSrc), .ExtSel(ExtSel), .WrRegData(WrRegData),
    .state(state)
  );

  // state_PCWre_IRWre_InsMemRW_RegWre_ALUSrcB_ALUOp_ALUM2Reg_RegOut_DataMemRw_PCSrc_ExtSel_WrRegData
  wire [18:0] ctl = {state, PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUOp,
                     ALUM2Reg, RegOut, DataMemRw, PCSrc, ExtSel, WrRegData};

  localparam logic [18:0] V_IF   = 19'b000_0_1_1_0_0_000_0_00_0_00_0_0;
  localparam logic [18:0] V_ID   = 19'b001_0_0_1_0_0_000_0_00_0_00_0_0;
  localparam logic [18:0] V_HALT = 19'b111_0_0_1_0_0_000_0_00_0_00_0_0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from IF and compares every cycle against the expected vectors.
  task automatic run_seq(input string name, input logic [5:0] op, input logic z,
                         input logic [18:0] exp [$]);
    opcode = op;
    zero   = z;
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL %s cycle %0d: observed %b required %b", name, i, ctl, exp[i]);
        fails++;
      end
      step();
    end
    checks++;
    if (state !== 3'b000) begin
      $display("FAIL %s return_to_if: observed state %b required 000", name, state);
      fails++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0;
    #1;
    checks++;
    if (PCWre !== 1'b0 || IRWre !== 1'b0) begin
      $display("FAIL reset_enables_pre: observed PCWre=%b IRWre=%b required 0 0", PCWre, IRWre);
      fails++;
    end
    step();
    checks++;
    if (state !== 3'b000 || PCWre !== 1'b0 || IRWre !== 1'b0 || RegWre !== 1'b0 || DataMemRw !== 1'b0) begin
      $display("FAIL reset_cycle1: observed state=%b PCWre=%b IRWre=%b required 000 0 0", state, PCWre, IRWre);
      fails++;
    end
    step();
    checks++;
    if (state !== 3'b000 || PCWre !== 1'b0 || IRWre !== 1'b0) begin
      $display("FAIL reset_cycle2: observed state=%b PCWre=%b IRWre=%b required 000 0 0", state, PCWre, IRWre);
      fails++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== V_IF) begin
      $display("FAIL reset_release_if: observed %b required %b", ctl, V_IF);
      fails++;
    end
  endtask

  task automatic test_rtype();
    run_seq("add", 6'b000000, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_0_000_0_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_10_0_00_0_1});
    run_seq("sub", 6'b000001, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_0_001_0_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_10_0_00_0_1});
    run_seq("and", 6'b010001, 1'b1, '{V_IF, V_ID,
            19'b010_0_0_1_0_0_100_0_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_10_0_00_0_1});
    run_seq("slt", 6'b100110, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_0_101_0_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_10_0_00_0_1});
  endtask

  task automatic test_immediate();
    run_seq("addi", 6'b000010, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_1_000_0_00_0_00_1_0,
            19'b100_1_0_1_1_0_000_0_01_0_00_0_1});
    run_seq("ori", 6'b010010, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_1_011_0_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_01_0_00_0_1});
  endtask

  task automatic test_memory();
    run_seq("lw", 6'b110001, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_1_000_0_00_0_00_1_0,
            19'b011_0_0_1_0_0_000_1_00_0_00_0_0,
            19'b100_1_0_1_1_0_000_0_01_0_00_0_1});
    run_seq("sw", 6'b110000, 1'b0, '{V_IF, V_ID,
            19'b010_0_0_1_0_1_000_0_00_0_00_1_0,
            19'b011_1_0_1_0_0_000_0_00_1_00_0_0});
  endtask

  task automatic test_branch();
    run_seq("beq_taken", 6'b110100, 1'b1, '{V_IF, V_ID,
            19'b010_1_0_1_0_0_001_0_00_0_01_1_0});
    run_seq("beq_not_taken", 6'b110100, 1'b0, '{V_IF, V_ID,
            19'b010_1_0_1_0_0_001_0_00_0_00_1_0});
  endtask

  task automatic test_jumps();
    run_seq("j", 6'b111000, 1'b0, '{V_IF,
            19'b001_1_0_1_0_0_000_0_00_0_11_0_0});
    run_seq("jr", 6'b111001, 1'b0, '{V_IF,
            19'b001_1_0_1_0_0_000_0_00_0_10_0_0});
    run_seq("jal", 6'b111010, 1'b0, '{V_IF,
            19'b001_1_0_1_1_0_000_0_00_0_11_0_0});
    run_seq("undefined_nop", 6'b000011, 1'b0, '{V_IF,
            19'b001_1_0_1_0_0_000_0_00_0_00_0_0});
  endtask

  task automatic test_reset_mid_instruction();
    opcode = 6'b000000; zero = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 3'b100) begin
      $display("FAIL midreset_reach_wb: observed state %b required 100", state);
      fails++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 19'b100_0_0_1_0_0_000_0_10_0_00_0_1) begin
      $display("FAIL midreset_wb_suppressed: observed %b required %b", ctl,
               19'b100_0_0_1_0_0_000_0_10_0_00_0_1);
      fails++;
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== V_IF) begin
      $display("FAIL midreset_back_to_if: observed %b required %b", ctl, V_IF);
      fails++;
    end
  endtask

  task automatic test_halt();
    opcode = 6'b111111; zero = 1'b0;
    checks++;
    if (ctl !== V_IF) begin
      $display("FAIL halt_if: observed %b required %b", ctl, V_IF);
      fails++;
    end
    step();
    checks++;
    if (ctl !== V_ID) begin
      $display("FAIL halt_id: observed %b required %b", ctl, V_ID);
      fails++;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ctl !== V_HALT) begin
        $display("FAIL halt_hold cycle %0d: observed %b required %b", i, ctl, V_HALT);
        fails++;
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'b000 || IRWre !== 1'b1) begin
      $display("FAIL halt_reset_exit: observed state=%b IRWre=%b required 000 1", state, IRWre);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_immediate();
    test_memory();
    test_branch();
    test_jumps();
    test_reset_mid_instruction();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control FSM for the multi-cycle CPU; drives every control input of the datapath.
- Consumes the datapath's 6-bit opcode (IR[31:26]) and ALU zero flag.
- Sequences each instruction through IF/ID/EXE/MEM/WB, asserting enables and mux selects per state.
- ISA is opcode-only: no funct field decode.

Parameters:
- OP_ADD, 6'b000000, register add
- OP_SUB, 6'b000001, register subtract
- OP_ADDI, 6'b000010, add sign-extended immediate
- OP_OR, 6'b010000, register or
- OP_AND, 6'b010001, register and
- OP_ORI, 6'b010010, or zero-extended immediate
- OP_SLT, 6'b100110, signed set-less-than
- OP_SW, 6'b110000, store word
- OP_LW, 6'b110001, load word
- OP_BEQ, 6'b110100, branch if equal
- OP_J, 6'b111000, jump
- OP_JR, 6'b111001, jump to register rs
- OP_JAL, 6'b111010, jump and link to $31
- OP_HALT, 6'b111111, stop fetching

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26] from datapath
- zero  in  1  ALU zero flag, combinational from datapath
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read (constant 1)
- RegWre  out  1  register file write enable
- ALUSrcB  out  1  0 = B register, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 011 or, 100 and, 101 signed slt
- ALUM2Reg  out  1  MDR source: 0 = ALU, 1 = data memory
- RegOut  out  2  write address: 00 = $31, 01 = rt, 10 = rd
- DataMemRw  out  1  1 = data memory write
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- WrRegData  out  1  register write data: 0 = PC+4, 1 = MDR
- state  out  3  current state, for debug

Behaviour:
- State encodings: IF = 000, ID = 001, EXE = 010, MEM = 011, WB = 100, HALT = 111.
- Outputs are combinational from state, opcode and zero.
- Defaults: all enables 0, all selects 0; InsMemRW always 1.
- Reset:
  - State goes to IF on the first clock edge with reset high.
  - While reset is high, PCWre, IRWre, RegWre and DataMemRw are forced to 0.
  - Reset mid-instruction abandons it; no partial write occurs in the reset cycle.
- IF: IRWre = 1. Next state is ID.
- ID:
  - j: PCSrc = 11, PCWre = 1, next state IF.
  - jr: PCSrc = 10, PCWre = 1, next state IF.
  - jal: RegWre = 1, RegOut = 00, WrRegData = 0 (PC is still old, so old PC+4 is linked), PCSrc = 11, PCWre = 1, next state IF.
  - halt: next state HALT.
  - Undefined opcode: PCSrc = 00, PCWre = 1, next state IF (treated as NOP).
  - All other opcodes: next state EXE.
- EXE:
  - ALUSrcB = 1 for addi, ori, lw, sw.
  - ExtSel = 1 for addi, lw, sw, beq; ExtSel = 0 for ori.
  - ALUOp: sub and beq use 001; or and ori use 011; and uses 100; slt uses 101; all others use 000.
  - ALUM2Reg = 0.
  - beq: PCSrc = zero ? 01 : 00, PCWre = 1, next state IF (3 cycles total).
  - lw, sw: next state MEM.
  - Others: next state WB.
- MEM:
  - sw: DataMemRw = 1, PCWre = 1, PCSrc = 00, next state IF (4 cycles).
  - lw: ALUM2Reg = 1, next state WB.
- WB:
  - RegWre = 1, WrRegData = 1, PCWre = 1, PCSrc = 00, next state IF.
  - RegOut = 01 for addi, ori, lw; RegOut = 10 for R-type.
  - Total: 4 cycles for ALU ops, 5 cycles for lw.
- HALT: all enables 0. State holds until reset.
- PCWre is asserted exactly once per instruction, in its final state.
- IRWre is asserted only in IF.
- opcode is stable from ID onward because IR is written only in IF.

Test Plan:
- Reset high for 2 cycles, then low -> state = 000; IRWre = 0 during reset and 1 in the first cycle after; PCWre = 0 throughout reset.
- opcode 000000 -> states IF, ID, EXE, WB; WB has RegWre = 1, RegOut = 10, WrRegData = 1, PCWre = 1; EXE has ALUOp = 000.
- opcode 110001 -> 5 states; EXE has ALUSrcB = 1, ExtSel = 1; MEM has ALUM2Reg = 1, DataMemRw = 0; WB has RegOut = 01.
- opcode 110100 with zero = 1, then with zero = 0 -> EXE has ALUOp = 001 and PCWre = 1; PCSrc = 01 and 00 respectively; back to IF after 3 cycles.
- opcode 111010 -> in ID: RegWre = 1, RegOut = 00, WrRegData = 0, PCSrc = 11, PCWre = 1; next state IF.
- opcode 111111 -> state 111 held for 10 cycles with all enables 0; reset then returns state to 000.
